// File: rtl/arch_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arch_defs_pkg
// Description : Shared architecture definitions for the instruction fetch
//               path. It holds the opcode encodings, the reset origin of the
//               program counter, the fetch state encoding and an
//               instruction-length lookup.
// Revision    : 1.0 - initial release
// ============================================================================
package arch_defs_pkg;

   // Program counter value loaded on reset.
   localparam logic [15:0] c_origin_default = 16'hF000;

   // Opcode encodings that the fetch unit needs to recognise.
   localparam logic [7:0] c_op_lda   = 8'h10;  // load A, 16-bit address
   localparam logic [7:0] c_op_ldi_a = 8'h20;  // load A, 8-bit immediate
   localparam logic [7:0] c_op_hlt   = 8'hF0;  // halt

   typedef enum logic [2:0] {
      S_INIT       = 3'd0,
      S_LATCH_ADDR = 3'd1,
      S_READ_BYTE  = 3'd2,
      S_LATCH_BYTE = 3'd3,
      S_CHK_MORE   = 3'd4,
      S_WAIT_EXEC  = 3'd5,
      S_HALT       = 3'd6
   } fetch_state_t;

   // Total instruction length in bytes, including the opcode byte.
   // Anything not recognised is treated as a single-byte instruction.
   function automatic logic [1:0] instr_len(input logic [7:0] op);
      logic [1:0] len;
      case (op)
         c_op_lda:   len = 2'd3;
         c_op_ldi_a: len = 2'd2;
         default:    len = 2'd1;
      endcase
      return len;
   endfunction

endpackage
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : 16-bit program counter with load, increment and hold.
//               Load has priority over increment; increment wraps modulo
//               2^16.
// Ports       : clk          - clock
//               rst          - synchronous active-high reset (to RESET_VALUE)
//               i_load       - load i_load_value
//               i_load_value - value to load
//               i_inc        - increment by one
//               o_pc         - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter #(
   parameter logic [15:0] RESET_VALUE = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [15:0] i_load_value,
   input  logic        i_inc,
   output logic [15:0] o_pc
);

   logic [15:0] r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_VALUE;
      end else if (i_load) begin
         r_pc <= i_load_value;
      end else if (i_inc) begin
         r_pc <= r_pc + 16'd1;
      end
   end

   assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Byte-serial instruction fetch. The unit reads 1 to 3 bytes per
//               instruction (4 cycles per byte) into the opcode/operand
//               registers, presents them to the control unit, and waits for
//               retirement. A jump reloads the PC on retirement. HLT
//               freezes the unit until reset.
// Ports       : clk           - clock
//               reset         - synchronous active-high reset
//               mem_address   - byte address presented to memory (MAR)
//               mem_read      - read strobe, data returns the next cycle
//               mem_data_in   - memory read data
//               exec_done     - current instruction retired (1-cycle pulse)
//               pc_load       - jump taken, qualifies pc_load_value
//               pc_load_value - jump target
//               instr_valid   - opcode/operands stable and valid
//               opcode        - instruction register
//               operand_lo    - second instruction byte
//               operand_hi    - third instruction byte
//               pc_out        - current program counter
//               halted        - HLT has been fetched
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import arch_defs_pkg::*;
#(
   parameter logic [15:0] ORIGIN = c_origin_default
) (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] mem_address,
   output logic        mem_read,
   input  logic [7:0]  mem_data_in,
   input  logic        exec_done,
   input  logic        pc_load,
   input  logic [15:0] pc_load_value,
   output logic        instr_valid,
   output logic [7:0]  opcode,
   output logic [7:0]  operand_lo,
   output logic [7:0]  operand_hi,
   output logic [15:0] pc_out,
   output logic        halted
);

   fetch_state_t r_state;
   fetch_state_t w_next_state;

   logic [15:0] r_mar;
   logic [7:0]  r_opcode;
   logic [7:0]  r_operand_lo;
   logic [7:0]  r_operand_hi;
   logic [1:0]  r_byte_idx;

   logic [15:0] w_pc;
   logic        w_pc_load;
   logic [15:0] w_pc_load_value;
   logic        w_pc_inc;
   logic        w_idx_clr;
   logic        w_idx_inc;
   logic        w_mar_load;
   logic        w_byte_latch;
   logic        w_more_bytes;

   // Another byte follows when (index + 1) is still below the length of the
   // opcode that was latched as byte 0.
   assign w_more_bytes = ({1'b0, r_byte_idx} + 3'd1) < {1'b0, instr_len(r_opcode)};

   // ---------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_INIT;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------
   // Next-state and control strobes
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state    = r_state;
      w_pc_load       = 1'b0;
      w_pc_load_value = ORIGIN;
      w_pc_inc        = 1'b0;
      w_idx_clr       = 1'b0;
      w_idx_inc       = 1'b0;
      w_mar_load      = 1'b0;
      w_byte_latch    = 1'b0;

      case (r_state)
         S_INIT: begin
            w_pc_load    = 1'b1;
            w_idx_clr    = 1'b1;
            w_next_state = S_LATCH_ADDR;
         end
         S_LATCH_ADDR: begin
            w_mar_load   = 1'b1;
            w_next_state = S_READ_BYTE;
         end
         S_READ_BYTE: begin
            w_next_state = S_LATCH_BYTE;
         end
         S_LATCH_BYTE: begin
            w_byte_latch = 1'b1;
            w_pc_inc     = 1'b1;
            w_next_state = S_CHK_MORE;
         end
         S_CHK_MORE: begin
            if (w_more_bytes) begin
               w_idx_inc    = 1'b1;
               w_next_state = S_LATCH_ADDR;
            end else if (r_opcode == c_op_hlt) begin
               w_next_state = S_HALT;
            end else begin
               w_next_state = S_WAIT_EXEC;
            end
         end
         S_WAIT_EXEC: begin
            if (exec_done) begin
               w_pc_load       = pc_load;
               w_pc_load_value = pc_load_value;
               w_idx_clr       = 1'b1;
               w_next_state    = S_LATCH_ADDR;
            end
         end
         S_HALT: begin
            w_next_state = S_HALT;
         end
         default: begin
            w_next_state = S_INIT;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Datapath registers: MAR, byte index, instruction bytes
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mar        <= 16'h0000;
         r_opcode     <= 8'h00;
         r_operand_lo <= 8'h00;
         r_operand_hi <= 8'h00;
         r_byte_idx   <= 2'd0;
      end else begin
         if (w_idx_clr) begin
            r_byte_idx <= 2'd0;
         end else if (w_idx_inc) begin
            r_byte_idx <= r_byte_idx + 2'd1;
         end

         if (w_mar_load) begin
            r_mar <= w_pc;
         end

         // Only the byte addressed by the index is written, so operands
         // beyond a short instruction keep whatever they held before.
         if (w_byte_latch) begin
            case (r_byte_idx)
               2'd0:    r_opcode     <= mem_data_in;
               2'd1:    r_operand_lo <= mem_data_in;
               default: r_operand_hi <= mem_data_in;
            endcase
         end
      end
   end

   program_counter #(
      .RESET_VALUE (ORIGIN)
   ) u_program_counter (
      .clk          (clk),
      .rst          (reset),
      .i_load       (w_pc_load),
      .i_load_value (w_pc_load_value),
      .i_inc        (w_pc_inc),
      .o_pc         (w_pc)
   );

   assign mem_address = r_mar;
   assign mem_read    = (r_state == S_READ_BYTE);
   assign instr_valid = (r_state == S_WAIT_EXEC) || (r_state == S_HALT);
   assign halted      = (r_state == S_HALT);
   assign opcode      = r_opcode;
   assign operand_lo  = r_operand_lo;
   assign operand_hi  = r_operand_hi;
   assign pc_out      = w_pc;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A schedule-level model
//               predicts every cycle's outputs from the instruction start
//               address, the instruction length and the 4-cycles-per-byte
//               rule. Directed scenarios add literal expectations, followed
//               by a randomized run with random jumps, retirements and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [15:0] ORG    = 16'hF000;
   localparam logic [7:0]  OP_LDA = arch_defs_pkg::c_op_lda;
   localparam logic [7:0]  OP_LDI = arch_defs_pkg::c_op_ldi_a;
   localparam logic [7:0]  OP_HLT = arch_defs_pkg::c_op_hlt;

   localparam int M_INIT  = 0;
   localparam int M_FETCH = 1;
   localparam int M_WAIT  = 2;
   localparam int M_HALT  = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] mem_address;
   logic        mem_read;
   logic [7:0]  mem_data_in = 8'h00;
   logic        exec_done = 1'b0;
   logic        pc_load = 1'b0;
   logic [15:0] pc_load_value = 16'h0000;
   logic        instr_valid;
   logic [7:0]  opcode;
   logic [7:0]  operand_lo;
   logic [7:0]  operand_hi;
   logic [15:0] pc_out;
   logic        halted;

   logic [7:0]  rom [0:65535];

   int n_checks = 0;
   int n_pass   = 0;
   int n_reads  = 0;

   fetch_unit #(.ORIGIN(ORG)) dut (
      .clk           (clk),
      .reset         (reset),
      .mem_address   (mem_address),
      .mem_read      (mem_read),
      .mem_data_in   (mem_data_in),
      .exec_done     (exec_done),
      .pc_load       (pc_load),
      .pc_load_value (pc_load_value),
      .instr_valid   (instr_valid),
      .opcode        (opcode),
      .operand_lo    (operand_lo),
      .operand_hi    (operand_hi),
      .pc_out        (pc_out),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // Memory: data for a read strobe appears the following cycle.
   always @(posedge clk) begin
      if (mem_read) mem_data_in <= rom[mem_address];
   end

   always @(negedge clk) begin
      if (mem_read === 1'b1) n_reads++;
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   function automatic int ref_len(input logic [7:0] op);
      if (op == OP_LDA) return 3;
      if (op == OP_LDI) return 2;
      return 1;
   endfunction

   // ---------------------------------------------------------------------
   // Reference model: one instruction = length*4 cycles starting at the
   // address-latch cycle; byte k is read in cycle 4k+1 of that window and
   // the PC has advanced past byte k from cycle 4k+3 on.
   // ---------------------------------------------------------------------
   bit          m_known = 1'b0;
   int          m_mode  = M_INIT;
   int          m_s     = 0;
   int          m_len   = 1;
   logic [15:0] m_pstart = ORG;
   logic [7:0]  m_b0, m_b1, m_b2;
   logic [7:0]  m_op = 8'h00, m_lo = 8'h00, m_hi = 8'h00;

   task automatic m_start(input logic [15:0] p);
      m_pstart = p;
      m_s      = 0;
      m_b0     = rom[p];
      m_b1     = rom[16'(p + 16'd1)];
      m_b2     = rom[16'(p + 16'd2)];
      m_len    = ref_len(m_b0);
      m_mode   = M_FETCH;
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_known = 1'b1;
         m_mode  = M_INIT;
         m_op    = 8'h00;
         m_lo    = 8'h00;
         m_hi    = 8'h00;
      end else begin
         case (m_mode)
            M_INIT: m_start(ORG);
            M_FETCH: begin
               m_s++;
               if (m_s == 4 * m_len) begin
                  m_op = m_b0;
                  if (m_len >= 2) m_lo = m_b1;
                  if (m_len == 3) m_hi = m_b2;
                  m_mode = (m_b0 == OP_HLT) ? M_HALT : M_WAIT;
               end
            end
            M_WAIT: begin
               if (exec_done)
                  m_start(pc_load ? pc_load_value : 16'(m_pstart + 16'(m_len)));
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      logic        e_read;
      logic        e_valid;
      logic [15:0] e_pc;
      if (m_known) begin
         e_read  = (m_mode == M_FETCH) && (m_s % 4 == 1);
         e_valid = (m_mode == M_WAIT) || (m_mode == M_HALT);
         case (m_mode)
            M_INIT:  e_pc = ORG;
            M_FETCH: e_pc = 16'(m_pstart + 16'(m_s / 4) + ((m_s % 4 == 3) ? 16'd1 : 16'd0));
            default: e_pc = 16'(m_pstart + 16'(m_len));
         endcase
         chk("mem_read", 16'(mem_read), 16'(e_read));
         if (e_read) chk("mem_address", mem_address, 16'(m_pstart + 16'(m_s / 4)));
         chk("instr_valid", 16'(instr_valid), 16'(e_valid));
         chk("halted", 16'(halted), 16'(m_mode == M_HALT));
         chk("pc_out", pc_out, e_pc);
         if (e_valid || m_mode == M_INIT) begin
            chk("opcode", 16'(opcode), 16'(m_op));
            chk("operand_lo", 16'(operand_lo), 16'(m_lo));
            chk("operand_hi", 16'(operand_hi), 16'(m_hi));
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------
   task automatic hold_reset();
      @(posedge clk); #1;
      reset = 1'b1; exec_done = 1'b0; pc_load = 1'b0;
      @(posedge clk); #1;
   endtask

   // Returns inside cycle 1 (the init cycle) after release.
   task automatic release_reset();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic next_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic wait_read(output logic [15:0] a);
      bit ok = 1'b0;
      a = 16'h0000;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (mem_read === 1'b1) begin
            ok = 1'b1;
            a  = mem_address;
         end
      end
      if (!ok) chk("read_timeout", 16'd0, 16'd1);
   endtask

   task automatic wait_valid();
      bit ok = 1'b0;
      for (int i = 0; i < 64 && !ok; i++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) ok = 1'b1;
      end
      if (!ok) chk("valid_timeout", 16'd0, 16'd1);
   endtask

   task automatic retire(input logic ld, input logic [15:0] tgt);
      @(posedge clk); #1;
      exec_done = 1'b1; pc_load = ld; pc_load_value = tgt;
      @(posedge clk); #1;
      exec_done = 1'b0; pc_load = 1'b0;
   endtask

   function automatic logic [7:0] rand_byte();
      int r = $urandom_range(0, 99);
      if (r < 30) return OP_LDA;
      if (r < 60) return OP_LDI;
      if (r < 62) return OP_HLT;
      return 8'($urandom);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [15:0] a;
      int          r0;

      for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
      rom[16'hF000] = OP_LDA;
      rom[16'hF001] = 8'h34;
      rom[16'hF002] = 8'h12;
      rom[16'hF003] = OP_HLT;

      // LDA then HLT from reset, with literal cycle positions.
      hold_reset();
      release_reset();
      @(negedge clk);                        // cycle 1
      chk("c1_pc", pc_out, 16'hF000);
      chk("c1_valid", 16'(instr_valid), 16'h0);
      next_cycles(1);                        // cycle 2
      chk("c2_read", 16'(mem_read), 16'h0);
      next_cycles(1);                        // cycle 3
      chk("c3_read", 16'(mem_read), 16'h1);
      chk("c3_addr", mem_address, 16'hF000);
      next_cycles(10);                       // cycle 13
      chk("c13_valid", 16'(instr_valid), 16'h0);
      next_cycles(1);                        // cycle 14
      chk("c14_valid", 16'(instr_valid), 16'h1);
      chk("c14_opcode", 16'(opcode), 16'(OP_LDA));
      chk("c14_lo", 16'(operand_lo), 16'h0034);
      chk("c14_hi", 16'(operand_hi), 16'h0012);
      chk("c14_pc", pc_out, 16'hF003);

      retire(1'b0, 16'h0000);
      repeat (6) @(posedge clk);
      @(negedge clk);
      chk("hlt_halted", 16'(halted), 16'h1);
      chk("hlt_pc", pc_out, 16'hF004);
      chk("hlt_opcode", 16'(opcode), 16'(OP_HLT));
      chk("hlt_lo_kept", 16'(operand_lo), 16'h0034);
      chk("hlt_hi_kept", 16'(operand_hi), 16'h0012);
      r0 = n_reads;
      retire(1'b1, 16'h1234);                // must be ignored in halt
      next_cycles(20);
      chk("hlt_no_reads", 16'(n_reads - r0), 16'h0);
      chk("hlt_pc_frozen", pc_out, 16'hF004);

      // Reset out of halt, then again while fetching byte 2 of LDA.
      hold_reset();
      release_reset();
      @(negedge clk);                        // cycle 1
      next_cycles(6);                        // cycle 7
      chk("b2_read", 16'(mem_read), 16'h1);
      chk("b2_addr", mem_address, 16'hF001);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_opcode", 16'(opcode), 16'h0);
      chk("rst_lo", 16'(operand_lo), 16'h0);
      chk("rst_hi", 16'(operand_hi), 16'h0);
      chk("rst_valid", 16'(instr_valid), 16'h0);
      chk("rst_read", 16'(mem_read), 16'h0);
      chk("rst_halted", 16'(halted), 16'h0);
      chk("rst_pc", pc_out, 16'hF000);
      reset = 1'b0;
      wait_read(a);
      chk("rst_refetch", a, 16'hF000);

      // LDI_A then jump to F010, then jump to FFFF with wrap to 0000.
      hold_reset();
      rom[16'hF000] = OP_LDI;
      rom[16'hF001] = 8'h55;
      rom[16'hF010] = OP_LDI;
      rom[16'hF011] = 8'h01;
      rom[16'hFFFF] = OP_LDI;
      rom[16'h0000] = 8'h77;
      release_reset();
      wait_valid();
      chk("ldi_opcode", 16'(opcode), 16'(OP_LDI));
      chk("ldi_lo", 16'(operand_lo), 16'h0055);
      chk("ldi_pc", pc_out, 16'hF002);
      retire(1'b1, 16'hF010);
      wait_read(a);
      chk("jmp_addr", a, 16'hF010);
      wait_valid();
      retire(1'b1, 16'hFFFF);
      wait_read(a);
      chk("wrap_read1", a, 16'hFFFF);
      wait_read(a);
      chk("wrap_read2", a, 16'h0000);
      wait_valid();
      chk("wrap_lo", 16'(operand_lo), 16'h0077);
      chk("wrap_pc", pc_out, 16'h0001);

      // exec_done during the read cycle must not disturb the fetch.
      hold_reset();
      rom[16'hF000] = OP_LDA;
      rom[16'hF001] = 8'h34;
      rom[16'hF002] = 8'h12;
      release_reset();                       // in cycle 1
      @(posedge clk);                        // cycle 2
      @(posedge clk); #1;                    // cycle 3, read cycle
      exec_done = 1'b1; pc_load = 1'b1; pc_load_value = 16'h1234;
      @(posedge clk); #1;
      exec_done = 1'b0; pc_load = 1'b0;
      wait_valid();
      chk("ign_opcode", 16'(opcode), 16'(OP_LDA));
      chk("ign_lo", 16'(operand_lo), 16'h0034);
      chk("ign_hi", 16'(operand_hi), 16'h0012);
      chk("ign_pc", pc_out, 16'hF003);

      // Randomized run against the model.
      hold_reset();
      for (int i = 0; i < 65536; i++) rom[i] = rand_byte();
      release_reset();
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if (reset) begin
            for (int j = 0; j < 64; j++) rom[16'($urandom)] = rand_byte();
            reset = 1'b0;
         end else if ($urandom_range(0, 149) == 0) begin
            reset = 1'b1;
         end
         exec_done     = ($urandom_range(0, 3) == 0);
         pc_load       = ($urandom_range(0, 1) == 0);
         pc_load_value = ($urandom_range(0, 2) == 0) ? 16'(16'hFFFD + 16'($urandom_range(0, 2)))
                                                     : 16'($urandom);
      end
      @(posedge clk); #1;
      exec_done = 1'b0; pc_load = 1'b0; reset = 1'b0;
      next_cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
